// File: rtl/adc_frame_scheduler.sv
// CS/SCLK frame sequencer for the serial ADC receive path; captures the receiver word as a 12-bit sample.
// Optional build macro ADC_AVG_EN: average four captures per reported sample.
module adc_frame_scheduler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 200,
  parameter int FRAME_BITS    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        start,
  input  logic [15:0] rx_word,
  output logic        CS,
  output logic        SCLK,
  output logic        busy,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic        overrun
);

  localparam int HC_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam int PER_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_RESYNC,
    ST_CAPTURE,
    ST_QUIET
  } state_e;

  state_e             state_q, state_d;
  logic [HC_W-1:0]    hc_q, hc_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               phase_q, phase_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               valid_q, valid_d;
  logic [11:0]        data_q, data_d;
  logic               ovr_q, ovr_d;

  logic               hc_last;
  logic               wrap;
  logic               busy_w;
  logic               unused_rx_bits;

`ifdef ADC_AVG_EN
  logic [13:0]        acc_q, acc_d;
  logic [1:0]         cap_cnt_q, cap_cnt_d;
  logic [13:0]        acc_sum;
`endif

  assign hc_last = (hc_q == HC_LAST);
  assign busy_w  = (state_q != ST_IDLE) && (state_q != ST_QUIET);
  assign wrap    = enable && (per_q == PER_LAST);
  assign unused_rx_bits = &{1'b0, rx_word[15:12]};

  // Period counter runs only while continuous sampling is enabled.
  always_comb begin
    per_d = per_q;
    if (!enable || state_q == ST_IDLE) begin
      per_d = '0;
    end else if (wrap) begin
      per_d = '0;
    end else begin
      per_d = per_q + PER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      hc_q      <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      per_q     <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ovr_q     <= 1'b0;
`ifdef ADC_AVG_EN
      acc_q     <= '0;
      cap_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      per_q     <= per_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ovr_q     <= ovr_d;
`ifdef ADC_AVG_EN
      acc_q     <= acc_d;
      cap_cnt_q <= cap_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable || start) begin
          state_d = ST_CS_SETUP;
          hc_d    = '0;
        end
      end
      ST_CS_SETUP: begin
        if (hc_last) begin
          state_d = ST_SHIFT;
          hc_d    = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
      end
      ST_SHIFT: begin
        if (hc_last) begin
          hc_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = ST_CS_HOLD;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
      end
      ST_CS_HOLD: begin
        if (hc_last) begin
          state_d = ST_RESYNC;
          hc_d    = '0;
          phase_d = 1'b0;
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
      end
      ST_RESYNC: begin
        if (hc_last) begin
          hc_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = enable ? ST_QUIET : ST_IDLE;
      end
      ST_QUIET: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d = ST_CS_SETUP;
          hc_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cs_d   = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_CS_HOLD));
    sclk_d = 1'b1;
    if (state_d == ST_SHIFT) begin
      sclk_d = phase_d;
    end else if (state_d == ST_RESYNC) begin
      // First RESYNC cycle keeps SCLK high so it never moves together with the CS rise.
      sclk_d = phase_d || (hc_d == '0);
    end

    ovr_d = busy_w && (wrap || (start && !enable));

`ifdef ADC_AVG_EN
    acc_d     = acc_q;
    cap_cnt_d = cap_cnt_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    acc_sum   = acc_q + {2'b00, rx_word[11:0]};
    if (state_q == ST_CAPTURE) begin
      if (cap_cnt_q == 2'd3) begin
        data_d    = acc_sum[13:2];
        valid_d   = 1'b1;
        acc_d     = '0;
        cap_cnt_d = '0;
      end else begin
        acc_d     = acc_sum;
        cap_cnt_d = cap_cnt_q + 2'd1;
      end
    end
    if (state_d == ST_IDLE && state_q != ST_IDLE) begin
      acc_d     = '0;
      cap_cnt_d = '0;
    end
`else
    valid_d = (state_q == ST_CAPTURE);
    data_d  = valid_d ? rx_word[11:0] : data_q;
`endif
  end

  assign CS           = cs_q;
  assign SCLK         = sclk_q;
  assign busy         = busy_w;
  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Directed bench for adc_frame_scheduler; with ADC_AVG_EN defined it runs the four-frame averaging sequence.
module tb_adc_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rx_word = 16'h0000;
  logic        cs, sclk, busy, sample_valid, overrun;
  logic [11:0] sample_data;

  logic        enable2 = 1'b0;
  logic [15:0] rx_word2 = 16'h0123;
  logic        cs2, sclk2, busy2, sample_valid2, overrun2;
  logic [11:0] sample_data2;

  always #5 clk = ~clk;

  adc_frame_scheduler #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .FRAME_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .rx_word(rx_word),
    .CS(cs), .SCLK(sclk), .busy(busy), .sample_valid(sample_valid),
    .sample_data(sample_data), .overrun(overrun)
  );

  adc_frame_scheduler #(.CLK_DIV(4), .SAMPLE_PERIOD(100), .FRAME_BITS(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .start(1'b0), .rx_word(rx_word2),
    .CS(cs2), .SCLK(sclk2), .busy(busy2), .sample_valid(sample_valid2),
    .sample_data(sample_data2), .overrun(overrun2)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  int cyc = 0, falls = 0, svs = 0, ovs = 0, lo = 0, hi = 0, simul = 0;
  int last_fall = 0, last_sv = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1;

  int falls2 = 0, svs2 = 0, ovs2 = 0, lo2 = 0, hi2 = 0, simul2 = 0;
  logic prev_cs2 = 1'b1, prev_sclk2 = 1'b1;

  // Event counters, sampled on the falling clock edge.
  always @(negedge clk) begin
    cyc++;
    if (reset_n && (prev_cs !== cs) && (prev_sclk !== sclk)) simul++;
    if (prev_sclk == 1'b0 && sclk == 1'b1) begin
      if (cs == 1'b0) lo++;
      else hi++;
    end
    if (prev_cs == 1'b1 && cs == 1'b0) begin
      falls++;
      last_fall = cyc;
    end
    if (sample_valid) begin
      svs++;
      last_sv = cyc;
    end
    if (overrun) ovs++;
    prev_cs   = cs;
    prev_sclk = sclk;
  end

  always @(negedge clk) begin
    if (reset_n && (prev_cs2 !== cs2) && (prev_sclk2 !== sclk2)) simul2++;
    if (prev_sclk2 == 1'b0 && sclk2 == 1'b1) begin
      if (cs2 == 1'b0) lo2++;
      else hi2++;
    end
    if (prev_cs2 == 1'b1 && cs2 == 1'b0) falls2++;
    if (sample_valid2) svs2++;
    if (overrun2) ovs2++;
    prev_cs2   = cs2;
    prev_sclk2 = sclk2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %-16s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %-16s %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_falls(input int target, input int budget, input string tag);
    int n = 0;
    while (falls < target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, falls, target);
  endtask

  task automatic wait_sv(input int target, input int budget, input string tag);
    int n = 0;
    while (svs < target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, svs, target);
  endtask

`ifdef ADC_AVG_EN
  logic [15:0] avg_vals [4];
`endif

  initial begin
    int c0, f0, s0, o0, lo0, hi0, first_fall;

    tick(3);
    check("rst_cs", cs, 1'b1);
    check("rst_sclk", sclk, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_data", sample_data, 12'h000);
    check("rst_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    tick(2);

`ifdef ADC_AVG_EN
    avg_vals[0] = 16'h0100;
    avg_vals[1] = 16'h0200;
    avg_vals[2] = 16'h0300;
    avg_vals[3] = 16'h0404;
    lo0 = lo;
    hi0 = hi;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_falls(k + 1, 250, "avg_frame_fall");
      rx_word = avg_vals[k];
      if (k == 3) check("avg_no_early_sv", svs, 0);
    end
    wait_sv(1, 250, "avg_valid");
    check("avg_data", sample_data, 12'h281);
    tick(1);
    check("avg_valid_width", sample_valid, 1'b0);
    check("avg_edges_lo", lo - lo0, 64);
    check("avg_edges_hi", hi - hi0, 4);
    enable = 1'b0;
    tick(250);
    check("avg_sv_total", svs, 1);
`else
    // Continuous mode: latency, capture and frame period.
    rx_word = 16'h0A5C;
    f0 = falls; s0 = svs; o0 = ovs; lo0 = lo; hi0 = hi;
    c0 = cyc;
    enable = 1'b1;
    wait_falls(f0 + 1, 5, "first_fall");
    check("cs_fall_lat", last_fall - c0, 1);
    first_fall = last_fall;
    wait_sv(s0 + 1, 200, "frame1_valid");
    check("valid_lat", last_sv - first_fall, 145);
    check("data_a5c", sample_data, 12'hA5C);
    tick(1);
    check("valid_width", sample_valid, 1'b0);
    check("quiet_busy", busy, 1'b0);
    wait_falls(f0 + 2, 100, "second_fall");
    check("period", last_fall - first_fall, 200);

    // Enable dropped mid-frame: frame finishes, then IDLE.
    enable = 1'b0;
    wait_sv(s0 + 2, 200, "frame2_valid");
    tick(2);
    check("idle_cs", cs, 1'b1);
    check("idle_sclk", sclk, 1'b1);
    check("idle_busy", busy, 1'b0);
    tick(250);
    check("no_refire", falls, f0 + 2);
    check("cont_edges_lo", lo - lo0, 32);
    check("cont_edges_hi", hi - hi0, 2);
    check("cont_overrun", ovs - o0, 0);

    // Single shot, second start while busy is dropped.
    f0 = falls; s0 = svs; o0 = ovs;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(48);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(300);
    check("ss_frames", falls - f0, 1);
    check("ss_valids", svs - s0, 1);
    check("ss_overrun", ovs - o0, 1);
    check("ss_cs_idle", cs, 1'b1);
    check("ss_sclk_idle", sclk, 1'b1);
    check("ss_busy", busy, 1'b0);

    // Reset during bit 7 of SHIFT.
    s0 = svs;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("mid_cs_low", cs, 1'b0);
    tick(61);
    check("bit7_sclk_low", sclk, 1'b0);
    reset_n = 1'b0;
    #1;
    check("arst_cs", cs, 1'b1);
    check("arst_sclk", sclk, 1'b1);
    check("arst_busy", busy, 1'b0);
    tick(3);
    check("arst_no_valid", svs, s0);
    lo0 = lo; hi0 = hi;
    rx_word = 16'hF123;
    reset_n = 1'b1;
    enable = 1'b1;
    wait_sv(s0 + 1, 300, "post_rst_valid");
    check("post_rst_lat", last_sv - last_fall, 145);
    check("post_rst_data", sample_data, 12'h123);
    check("post_rst_lo", lo - lo0, 16);
    check("post_rst_hi", hi - hi0, 1);
    enable = 1'b0;
    tick(200);

    // Short period: every other trigger lands inside a frame.
    enable2 = 1'b1;
    tick(450);
    enable2 = 1'b0;
    tick(250);
    check("sp100_frames", falls2, 3);
    check("sp100_valids", svs2, 3);
    check("sp100_overrun", ovs2, 2);
    check("sp100_lo", lo2, 48);
    check("sp100_hi", hi2, 3);
    check("sp100_simul", simul2, 0);
`endif

    check("cs_sclk_simul", simul, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
